// File: rtl/move_slot_scheduler_pkg.sv
// move_slot_scheduler_pkg: FSM state encoding and parameter defaults for the move-slot scheduler
package move_slot_scheduler_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, WAIT = 2'd2} state_t;
  localparam int N_REQ_DEF = 4;
  localparam int TIMEOUT_DEF = 64;
endpackage

// File: rtl/move_slot_scheduler_rr_pick.sv
// move_slot_scheduler_rr_pick: combinational round-robin picker, first set bit of cand at or above ptr with wrap
//   cand : candidate request bits
//   ptr  : index where the search starts
//   pick : chosen index (0 when nothing is set)
//   any  : at least one candidate present
module move_slot_scheduler_rr_pick #(
  parameter int N_REQ = 4,
  localparam int IDW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] cand,
  input  logic [IDW-1:0]   ptr,
  output logic [IDW-1:0]   pick,
  output logic             any
);
  logic [2*N_REQ-1:0] dbl;
  // Lower half keeps only bits at or above ptr, upper half is the wrapped copy;
  // the lowest set bit of the concatenation is the round-robin winner.
  always_comb begin
    dbl = {cand, cand & ~((N_REQ'(1) << ptr) - N_REQ'(1))};
    pick = '0;
    for (int i = 2 * N_REQ - 1; i >= 0; i--)
      if (dbl[i]) pick = IDW'(i >= N_REQ ? i - N_REQ : i);
    any = |cand;
  end
endmodule

// File: rtl/move_slot_scheduler.sv
// move_slot_scheduler: per-frame round-robin time-sharing of the movement/collision unit between sprites
//   clk, rst_n   : clock, asynchronous active-low reset
//   frame_tick   : starts a service round (latches req)
//   req          : per-sprite move request level
//   done         : move unit finished the granted sprite
//   gnt, sel     : registered one-hot grant and its index
//   busy         : round in progress
//   frame_done   : pulse when a round completes
//   overrun      : pulse when frame_tick arrives during a round
//   timeout_err  : pulse when the watchdog releases a grant
module move_slot_scheduler
  import move_slot_scheduler_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  localparam int IDW = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDW-1:0]   sel,
  output logic             busy,
  output logic             frame_done,
  output logic             overrun,
  output logic             timeout_err
);
  localparam int WDW = $clog2(TIMEOUT);
  state_t           state;
  logic [N_REQ-1:0] pending;
  logic [IDW-1:0]   ptr, pick;
  logic [WDW-1:0]   wdog;
  logic             any, expire;
  // Sprites that dropped req since the tick are masked out before picking.
  move_slot_scheduler_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .cand(pending & req),
    .ptr (ptr),
    .pick(pick),
    .any (any)
  );
  assign expire = wdog == WDW'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      pending     <= '0;
      ptr         <= '0;
      wdog        <= '0;
      gnt         <= '0;
      sel         <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
      overrun     <= frame_tick && state != IDLE;
      case (state)
        IDLE: if (frame_tick) begin
          pending    <= req;
          state      <= |req ? SCAN : IDLE;
          busy       <= |req;
          frame_done <= ~|req;
        end
        SCAN: if (!any) begin
          pending    <= '0;
          state      <= IDLE;
          busy       <= 1'b0;
          frame_done <= 1'b1;
        end else begin
          gnt   <= N_REQ'(1) << pick;
          sel   <= pick;
          wdog  <= '0;
          state <= WAIT;
        end
        WAIT: if (done || expire) begin
          pending[sel] <= 1'b0;
          ptr          <= sel == IDW'(N_REQ - 1) ? '0 : sel + 1'b1;
          gnt          <= '0;
          timeout_err  <= ~done;
          state        <= SCAN;
        end else wdog <= wdog + 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_move_slot_scheduler.sv
// tb_move_slot_scheduler: scoreboard bench with a rotated-order round model and a random-latency move unit
module tb_move_slot_scheduler;
  logic       clk = 0, rst_n = 0, frame_tick = 0, done_r = 0, done_kick = 0, done;
  logic [3:0] req = 0, gnt, pg = 0;
  logic [1:0] sel, ps = 0;
  logic       busy, frame_done, overrun, timeout_err;
  int n_chk = 0, n_fail = 0, cyc = 0;
  int fd_cnt = 0, fd_cyc = 0, fall_cyc = 0, to_cnt = 0, ov_cnt = 0, exp_to = 0, exp_ov = 0;
  int m_ptr = 0, hi_len = 0, last_len = 0, dly = 0, cnt = 0, force_dly = 0, ok;
  bit hold_done = 0, in_rst = 0;
  int exp_q[$];

  assign done = done_r | done_kick;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  move_slot_scheduler dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .req(req), .done(done),
    .gnt(gnt), .sel(sel), .busy(busy), .frame_done(frame_done),
    .overrun(overrun), .timeout_err(timeout_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Reference: each round serves requested sprites once in rotated order starting at the
  // sprite after the last one served in any earlier round.
  function automatic int push_round(input logic [3:0] r, input logic [3:0] skip);
    logic [3:0] s = r & ~skip;
    int last = -1, n = 0, k2;
    for (int k = 0; k < 4; k++) begin
      k2 = (m_ptr + k) % 4;
      if (s[k2]) begin
        exp_q.push_back(k2);
        last = k2;
        n++;
      end
    end
    if (last >= 0) m_ptr = (last + 1) % 4;
    return n;
  endfunction

  function automatic int pick_dly();
    int r = $urandom_range(0, 9);
    return r < 7 ? r + 1 : r == 7 ? 64 : r == 8 ? 65 : 2;
  endfunction

  // Move unit: answers done dly cycles into each grant; dly > 64 means the watchdog must fire.
  initial forever begin
    @(negedge clk);
    if (gnt != 0) begin
      cnt++;
      if (cnt == 1) begin
        dly = hold_done ? 1000 : force_dly > 0 ? force_dly : pick_dly();
        if (dly > 64) exp_to++;
      end
      done_r = cnt == dly;
    end else begin
      cnt = 0;
      done_r = 0;
    end
  end

  // Monitor
  always @(negedge clk) begin
    int e;
    if (gnt != 0 && pg == 0) begin
      if (exp_q.size() == 0) chk("unexpected_gnt", gnt, 0);
      else begin
        e = exp_q.pop_front();
        chk("gnt_order", gnt, 32'(1) << e);
        chk("sel", sel, e);
      end
    end
    if (gnt != 0 && pg != 0) begin
      chk("gnt_stable", gnt, pg);
      chk("sel_stable", sel, ps);
    end
    if (gnt != 0) hi_len++;
    if (gnt == 0 && pg != 0) begin
      fall_cyc = cyc;
      last_len = hi_len;
      if (!in_rst) chk("gnt_len", hi_len, dly > 64 ? 64 : dly);
      hi_len = 0;
    end
    if (frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
    if (timeout_err) to_cnt++;
    if (overrun) ov_cnt++;
    pg = gnt;
    ps = sel;
  end

  task automatic wait_gnt(output int okv);
    okv = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #1;
      if (gnt != 0) begin
        okv = 1;
        break;
      end
    end
    chk("wait_gnt", okv, 1);
  endtask

  task automatic round(input logic [3:0] r, input logic [3:0] skip, input bit ov, input bit lat);
    int fd0, n, okv;
    fd0 = fd_cnt;
    n = push_round(r, skip);
    if (ov) exp_ov++;
    @(posedge clk);
    #2 req = r;
    frame_tick = 1;
    @(posedge clk);
    #1;
    if (lat) begin
      chk("lat_busy", busy, 1);
      chk("lat_gnt_low", gnt, 0);
    end
    if (r == 0) begin
      chk("empty_fd", frame_done, 1);
      chk("empty_busy", busy, 0);
    end
    #1 frame_tick = 0;
    if (lat) begin
      @(posedge clk);
      #1 chk("lat_gnt", gnt != 0, 1);
    end
    if (skip != 0 || ov) begin
      wait_gnt(okv);
      #1 req = r & ~skip;
      if (ov) begin
        frame_tick = 1;
        @(posedge clk);
        #2 frame_tick = 0;
      end
    end
    okv = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      if (fd_cnt != fd0) begin
        okv = 1;
        break;
      end
    end
    chk("fd_seen", okv, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("fd_once", fd_cnt - fd0, 1);
    chk("all_served", exp_q.size(), 0);
    chk("idle_busy", busy, 0);
    chk("timeouts", to_cnt, exp_to);
    chk("overruns", ov_cnt, exp_ov);
    if (n > 0) chk("fd_after_release", fd_cyc, fall_cyc + 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_sel", sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_ov", overrun, 0);
    chk("rst_to", timeout_err, 0);
    @(posedge clk);
    #2 rst_n = 1;
    force_dly = 3;
    round(4'b1011, 4'b0000, 0, 1);
    force_dly = 0;
    @(posedge clk);
    #2 done_kick = 1;
    @(posedge clk);
    #2 done_kick = 0;
    @(posedge clk);
    #1;
    chk("stray_done_busy", busy, 0);
    chk("stray_done_gnt", gnt, 0);
    round(4'b0110, 4'b0100, 0, 0);
    round(4'b0111, 4'b0000, 0, 0);
    hold_done = 1;
    round(4'b0100, 4'b0000, 0, 0);
    hold_done = 0;
    chk("timeout_len", last_len, 64);
    round(4'b1111, 4'b0000, 1, 0);
    round(4'b0011, 4'b0010, 0, 0);
    round(4'b0000, 4'b0000, 0, 0);
    for (int i = 0; i < 20; i++) begin
      logic [3:0] r;
      r = 4'($urandom_range(0, 15));
      round(r, 4'b0000, r != 0 && $urandom_range(0, 3) == 0, 0);
    end
    force_dly = 5;
    void'(push_round(4'b1111, 4'b0000));
    @(posedge clk);
    #2 req = 4'b1111;
    frame_tick = 1;
    @(posedge clk);
    #2 frame_tick = 0;
    wait_gnt(ok);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 in_rst = 1;
    rst_n = 0;
    #1;
    chk("async_rst_gnt", gnt, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_sel", sel, 0);
    exp_q.delete();
    m_ptr = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    @(posedge clk);
    #1 chk("post_rst_busy", busy, 0);
    in_rst = 0;
    round(4'b1111, 4'b0000, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
